// File: rtl/sc_to_wc.sv
// Screen-to-world coordinate converter: x_wc = ceil(x_sc * 2^(WIDTH-2) / res_y), y likewise.
// Two lockstep restoring dividers, one quotient bit per cycle, valid/ready on both sides.
module sc_to_wc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      x_sc,
    input  logic [10:0]      y_sc,
    input  logic [10:0]      res_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_wc,
    output logic [WIDTH-1:0] y_wc,
    output logic             sat,
    output logic             div_zero
);

    localparam int D  = WIDTH + 9;
    localparam int CW = $clog2(D);
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One restoring step: returns {new remainder, quotient bit}.
    function automatic logic [12:0] div_step(input logic [11:0] rem,
                                             input logic        din,
                                             input logic [10:0] divisor);
        logic [11:0] trial;
        trial = {rem[10:0], din};
        if (trial >= {1'b0, divisor}) begin
            return {trial - {1'b0, divisor}, 1'b1};
        end else begin
            return {trial, 1'b0};
        end
    endfunction

    // Ceiling round then clamp to WIDTH bits: returns {saturated, value}.
    function automatic logic [WIDTH:0] finalise(input logic [D-1:0] q,
                                                input logic [11:0]  rem);
        logic [D-1:0] qr;
        qr = q + {{(D-1){1'b0}}, (rem != 12'd0)};
        if (qr[D-1:WIDTH] != {(D-WIDTH){1'b0}}) begin
            return {1'b1, {WIDTH{1'b1}}};
        end else begin
            return {1'b0, qr[WIDTH-1:0]};
        end
    endfunction

    state_t           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [10:0]      divisor_q,  divisor_d;
    logic [D-1:0]     dvd_x_q,    dvd_x_d;
    logic [D-1:0]     dvd_y_q,    dvd_y_d;
    logic [D-1:0]     quo_x_q,    quo_x_d;
    logic [D-1:0]     quo_y_q,    quo_y_d;
    logic [11:0]      rem_x_q,    rem_x_d;
    logic [11:0]      rem_y_q,    rem_y_d;
    logic [WIDTH-1:0] x_wc_q,     x_wc_d;
    logic [WIDTH-1:0] y_wc_q,     y_wc_d;
    logic             sat_q,      sat_d;
    logic             div_zero_q, div_zero_d;

    logic [12:0]      step_x,     step_y;
    logic [D-1:0]     quo_x_next, quo_y_next;
    logic [WIDTH:0]   fin_x,      fin_y;

    // Next-state, datapath and result logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        dvd_x_d    = dvd_x_q;
        dvd_y_d    = dvd_y_q;
        quo_x_d    = quo_x_q;
        quo_y_d    = quo_y_q;
        rem_x_d    = rem_x_q;
        rem_y_d    = rem_y_q;
        x_wc_d     = x_wc_q;
        y_wc_d     = y_wc_q;
        sat_d      = sat_q;
        div_zero_d = div_zero_q;

        step_x     = div_step(rem_x_q, dvd_x_q[D-1], divisor_q);
        step_y     = div_step(rem_y_q, dvd_y_q[D-1], divisor_q);
        quo_x_next = {quo_x_q[D-2:0], step_x[0]};
        quo_y_next = {quo_y_q[D-2:0], step_y[0]};
        // Rounding uses this cycle's step so the last bit is folded in on the DIV->DONE edge.
        fin_x      = finalise(quo_x_next, step_x[12:1]);
        fin_y      = finalise(quo_y_next, step_y[12:1]);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divisor_d = res_y;
                    if (res_y == 11'd0) begin
                        x_wc_d     = {WIDTH{1'b1}};
                        y_wc_d     = {WIDTH{1'b1}};
                        sat_d      = 1'b0;
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        dvd_x_d = {x_sc, {(WIDTH-2){1'b0}}};
                        dvd_y_d = {y_sc, {(WIDTH-2){1'b0}}};
                        quo_x_d = {D{1'b0}};
                        quo_y_d = {D{1'b0}};
                        rem_x_d = 12'd0;
                        rem_y_d = 12'd0;
                        cnt_d   = CNT_LAST;
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                dvd_x_d = {dvd_x_q[D-2:0], 1'b0};
                dvd_y_d = {dvd_y_q[D-2:0], 1'b0};
                quo_x_d = quo_x_next;
                quo_y_d = quo_y_next;
                rem_x_d = step_x[12:1];
                rem_y_d = step_y[12:1];
                if (cnt_q == {CW{1'b0}}) begin
                    x_wc_d     = fin_x[WIDTH-1:0];
                    y_wc_d     = fin_y[WIDTH-1:0];
                    sat_d      = fin_x[WIDTH] | fin_y[WIDTH];
                    div_zero_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            divisor_q  <= 11'd0;
            dvd_x_q    <= {D{1'b0}};
            dvd_y_q    <= {D{1'b0}};
            quo_x_q    <= {D{1'b0}};
            quo_y_q    <= {D{1'b0}};
            rem_x_q    <= 12'd0;
            rem_y_q    <= 12'd0;
            x_wc_q     <= {WIDTH{1'b0}};
            y_wc_q     <= {WIDTH{1'b0}};
            sat_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            dvd_x_q    <= dvd_x_d;
            dvd_y_q    <= dvd_y_d;
            quo_x_q    <= quo_x_d;
            quo_y_q    <= quo_y_d;
            rem_x_q    <= rem_x_d;
            rem_y_q    <= rem_y_d;
            x_wc_q     <= x_wc_d;
            y_wc_q     <= y_wc_d;
            sat_q      <= sat_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x_wc      = x_wc_q;
    assign y_wc      = y_wc_q;
    assign sat       = sat_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_sc_to_wc.sv
// Directed bench for sc_to_wc (WIDTH=32): hand-computed vectors, latency, back-pressure,
// mid-divide reset and a short random round-trip sweep against a 64-bit reference.
module tb_sc_to_wc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] x_sc, y_sc, res_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_wc, y_wc;
    logic        sat, div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    sc_to_wc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_sc(x_sc), .y_sc(y_sc), .res_y(res_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_wc(x_wc), .y_wc(y_wc), .sat(sat), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {sat, ceil(s*2^30/r) clamped to 32 bits}
    function automatic logic [32:0] model(input logic [10:0] s, input logic [10:0] r);
        logic [63:0] q;
        q = (({53'd0, s}) << 30) + {53'd0, r} - 64'd1;
        q = q / {53'd0, r};
        if (q > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
        else return {1'b0, q[31:0]};
    endfunction

    // Issue one request, then scramble the inputs; return cycles from accept to out_valid.
    task automatic do_req(input logic [10:0] xs, input logic [10:0] ys, input logic [10:0] r,
                          output int lat);
        @(negedge clk);
        chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
        x_sc = xs; y_sc = ys; res_y = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_sc = ~xs; y_sc = ~ys; res_y = r + 11'd7;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] hx, hy;
        logic [32:0] ex, ey;
        logic [10:0] rx, ry, rr;
        logic        seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_sc = 11'd0; y_sc = 11'd0; res_y = 11'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_x_wc", {32'd0, x_wc}, 64'd0);
        chk("rst_y_wc", {32'd0, y_wc}, 64'd0);
        chk("rst_flags", {62'd0, sat, div_zero}, 64'd0);

        // 1: basic conversion and latency
        do_req(11'd1280, 11'd400, 11'd800, lat);
        chk("t1_latency", 64'(lat), 64'd42);
        chk("t1_x_wc", {32'd0, x_wc}, 64'h6666_6667);
        chk("t1_y_wc", {32'd0, y_wc}, 64'h2000_0000);
        chk("t1_flags", {62'd0, sat, div_zero}, 64'd0);
        chk("t1_in_ready_done", {63'd0, in_ready}, 64'd0);
        release_out();
        chk("t1_x_wc_held", {32'd0, x_wc}, 64'h6666_6667);

        // 2: zero and exact full unit, with round trip
        do_req(11'd0, 11'd800, 11'd800, lat);
        chk("t2_latency", 64'(lat), 64'd42);
        chk("t2_x_wc", {32'd0, x_wc}, 64'd0);
        chk("t2_y_wc", {32'd0, y_wc}, 64'h4000_0000);
        chk("t2_rt_y", (({32'd0, y_wc}) * 64'd800) >> 30, 64'd800);
        chk("t2_rt_x", (({32'd0, x_wc}) * 64'd800) >> 30, 64'd0);
        release_out();

        // 3: saturation on x only
        do_req(11'd2047, 11'd1, 11'd1, lat);
        chk("t3_x_wc", {32'd0, x_wc}, 64'hFFFF_FFFF);
        chk("t3_y_wc", {32'd0, y_wc}, 64'h4000_0000);
        chk("t3_sat", {63'd0, sat}, 64'd1);
        chk("t3_div_zero", {63'd0, div_zero}, 64'd0);
        release_out();

        // 4: divide by zero short path
        do_req(11'd123, 11'd456, 11'd0, lat);
        chk("t4_latency", 64'(lat), 64'd1);
        chk("t4_x_wc", {32'd0, x_wc}, 64'hFFFF_FFFF);
        chk("t4_y_wc", {32'd0, y_wc}, 64'hFFFF_FFFF);
        chk("t4_div_zero", {63'd0, div_zero}, 64'd1);
        chk("t4_sat", {63'd0, sat}, 64'd0);
        release_out();

        // 5: back-pressure in DONE with a competing request on the input
        do_req(11'd1280, 11'd400, 11'd800, lat);
        chk("t5_latency", 64'(lat), 64'd42);
        x_sc = 11'd5; y_sc = 11'd6; res_y = 11'd0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("t5_hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("t5_hold_x_wc", {32'd0, x_wc}, 64'h6666_6667);
            chk("t5_hold_flags", {62'd0, sat, div_zero}, 64'd0);
        end
        in_valid = 1'b0;
        release_out();
        do_req(11'd0, 11'd800, 11'd800, lat);
        chk("t5_next_y_wc", {32'd0, y_wc}, 64'h4000_0000);
        release_out();

        // 6: reset at DIV cycle 10 aborts the operation
        @(negedge clk);
        x_sc = 11'd1280; y_sc = 11'd400; res_y = 11'd800; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_x_wc", {32'd0, x_wc}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("t6_no_result", {63'd0, seen}, 64'd0);
        do_req(11'd1280, 11'd400, 11'd800, lat);
        chk("t6_after_latency", 64'(lat), 64'd42);
        chk("t6_after_x_wc", {32'd0, x_wc}, 64'h6666_6667);
        release_out();

        // Random sweep with round-trip check on non-clamped coordinates
        for (int k = 0; k < 8; k++) begin
            rr = 11'($urandom_range(1, 2047));
            rx = 11'($urandom_range(0, 2047));
            ry = 11'($urandom_range(0, 2047));
            ex = model(rx, rr);
            ey = model(ry, rr);
            do_req(rx, ry, rr, lat);
            hx = x_wc; hy = y_wc;
            chk("rnd_latency", 64'(lat), 64'd42);
            chk("rnd_x_wc", {32'd0, hx}, {32'd0, ex[31:0]});
            chk("rnd_y_wc", {32'd0, hy}, {32'd0, ey[31:0]});
            chk("rnd_sat", {63'd0, sat}, {63'd0, ex[32] | ey[32]});
            if (!ex[32]) chk("rnd_rt_x", (({32'd0, hx}) * {53'd0, rr}) >> 30, {53'd0, rx});
            if (!ey[32]) chk("rnd_rt_y", (({32'd0, hy}) * {53'd0, rr}) >> 30, {53'd0, ry});
            release_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
